// File: rtl/lfsr32_checker.sv
// Checker for a received 32-bit XNOR LFSR state stream: hunts, synchronises, then flywheels.
// Optional macro LFSR32_CHECKER_BITERR_EN makes ERR_COUNT accumulate mismatching bits instead of words.
module lfsr32_checker #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 8,
    parameter int CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             E,
    input  logic [31:0]      DATA_IN,
    input  logic             CLEAR,
    output logic             LOCKED,
    output logic             ERR,
    output logic [CNT_W-1:0] ERR_COUNT,
    output logic [CNT_W-1:0] WORD_COUNT
);

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_SYNC = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    localparam int          SW     = ((CNT_W > 6) ? CNT_W : 6) + 1;
    localparam logic [3:0]  LOCK_C = 4'(LOCK_CNT);
    localparam logic [3:0]  LOSS_C = 4'(LOSS_CNT);
    localparam logic [31:0] ALL1   = 32'hFFFF_FFFF;

    state_t      state_r, state_s;
    logic [31:0] pred_r, pred_s;
    logic [3:0]  match_r, match_s;
    logic [3:0]  miss_r, miss_s;
    logic        err_s;
    logic        err_inc_s;
    logic        word_inc_s;
    logic [5:0]  err_amt_s;

    function automatic logic [31:0] nxt(input logic [31:0] s);
        nxt = {s[30:0], ~(s[31] ^ s[21] ^ s[1] ^ s[0])};
    endfunction

`ifdef LFSR32_CHECKER_BITERR_EN
    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] c;
        c = 6'd0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'd0, v[i]};
        end
        popcount32 = c;
    endfunction
`endif

    // Add an increment to a counter, pinning at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt, input logic [5:0] amt);
        logic [SW-1:0] sum;
        logic [SW-1:0] cap;
        sum = SW'(cnt) + SW'(amt);
        cap = SW'({CNT_W{1'b1}});
        if (sum > cap) begin
            sat_add = {CNT_W{1'b1}};
        end else begin
            sat_add = sum[CNT_W-1:0];
        end
    endfunction

    // Next-state and per-strobe event decode; nothing moves without a strobe.
    always_comb begin
        state_s    = state_r;
        pred_s     = pred_r;
        match_s    = match_r;
        miss_s     = miss_r;
        err_s      = 1'b0;
        err_inc_s  = 1'b0;
        word_inc_s = 1'b0;
        err_amt_s  = 6'd1;
        if (E) begin
            case (state_r)
                ST_HUNT: begin
                    if (DATA_IN == ALL1) begin
                        state_s = ST_HUNT;
                    end else begin
                        pred_s  = nxt(DATA_IN);
                        match_s = 4'd0;
                        state_s = ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (DATA_IN == ALL1) begin
                        state_s = ST_HUNT;
                        match_s = 4'd0;
                    end else if (DATA_IN == pred_r) begin
                        pred_s  = nxt(DATA_IN);
                        match_s = match_r + 4'd1;
                        if (match_s == LOCK_C) begin
                            state_s = ST_LOCK;
                            miss_s  = 4'd0;
                        end else begin
                            state_s = ST_SYNC;
                        end
                    end else begin
                        pred_s  = nxt(DATA_IN);
                        match_s = 4'd0;
                    end
                end
                ST_LOCK: begin
                    // Flywheel: the prediction never re-seeds from received data once locked.
                    pred_s     = nxt(pred_r);
                    word_inc_s = 1'b1;
                    if (DATA_IN == pred_r) begin
                        miss_s = 4'd0;
                    end else begin
                        err_s     = 1'b1;
                        err_inc_s = 1'b1;
`ifdef LFSR32_CHECKER_BITERR_EN
                        err_amt_s = popcount32(DATA_IN ^ pred_r);
`else
                        err_amt_s = 6'd1;
`endif
                        if ((miss_r + 4'd1) == LOSS_C) begin
                            state_s = ST_HUNT;
                            match_s = 4'd0;
                            miss_s  = 4'd0;
                        end else begin
                            miss_s  = miss_r + 4'd1;
                        end
                    end
                end
                default: begin
                    state_s = ST_HUNT;
                    match_s = 4'd0;
                    miss_s  = 4'd0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Sequence tracking state and the registered error pulse.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r <= ST_HUNT;
            pred_r  <= 32'd0;
            match_r <= 4'd0;
            miss_r  <= 4'd0;
            ERR     <= 1'b0;
        end else begin
            state_r <= state_s;
            pred_r  <= pred_s;
            match_r <= match_s;
            miss_r  <= miss_s;
            ERR     <= err_s;
        end
    end

    // Error counter: CLEAR wins but still keeps a coincident increment.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ERR_COUNT <= {CNT_W{1'b0}};
        end else if (CLEAR) begin
            ERR_COUNT <= err_inc_s ? sat_add({CNT_W{1'b0}}, err_amt_s) : {CNT_W{1'b0}};
        end else if (err_inc_s) begin
            ERR_COUNT <= sat_add(ERR_COUNT, err_amt_s);
        end else begin
            ERR_COUNT <= ERR_COUNT;
        end
    end

    // Word counter: counts every strobe checked while locked.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            WORD_COUNT <= {CNT_W{1'b0}};
        end else if (CLEAR) begin
            WORD_COUNT <= word_inc_s ? sat_add({CNT_W{1'b0}}, 6'd1) : {CNT_W{1'b0}};
        end else if (word_inc_s) begin
            WORD_COUNT <= sat_add(WORD_COUNT, 6'd1);
        end else begin
            WORD_COUNT <= WORD_COUNT;
        end
    end

    assign LOCKED = (state_r == ST_LOCK);

endmodule
